// File: rtl/better_and_gate_pkg.sv
// Shared defaults and counter helpers for the better_and_gate block.
`timescale 1ns/1ps
package better_and_gate_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 16;

  // All-ones value of a w-bit counter, clamped to the 32-bit helper range
  function automatic logic [31:0] cnt_max(input int unsigned w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam logic [31:0] DEF_CNT_MAX = cnt_max(DEF_CNT_W);

endpackage

// File: rtl/better_and_gate_edge_det.sv
// Level-change detector: remembers last cycle's level, flags 0->1 and 1->0.
`timescale 1ns/1ps
module and_gate_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_hist <= 1'b0;
    else     r_hist <= i_level;
  end

  // i_level is itself a flop, so both pulses are clean and mutually exclusive
  assign o_rise = i_level & ~r_hist;
  assign o_fall = ~i_level & r_hist;

endmodule

// File: rtl/better_and_gate.sv
// Bitwise AND with registered copy, all-ones flag and edge pulses.
// Optional high-cycle statistics counter enabled by BETTER_AND_GATE_STATS_EN.
`timescale 1ns/1ps
module better_and_gate
  import better_and_gate_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             all_high,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] high_cnt
);

  logic [WIDTH-1:0] w_and;
  logic             w_all;
  logic [WIDTH-1:0] r_out_q;
  logic             r_all_high;

  assign w_and = a & b;
  assign w_all = &w_and;
  assign out   = w_and;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_q    <= '0;
      r_all_high <= 1'b0;
    end else begin
      r_out_q    <= w_and;
      r_all_high <= w_all;
    end
  end

  assign out_q    = r_out_q;
  assign all_high = r_all_high;

  and_gate_edge_det u_edge_det (
    .clk     (clk),
    .rst     (rst),
    .i_level (r_all_high),
    .o_rise  (rise),
    .o_fall  (fall)
  );

`ifdef BETTER_AND_GATE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] r_high_cnt;

  // Clear wins over increment; counter holds at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_high_cnt <= '0;
    else if (cnt_clr)                          r_high_cnt <= '0;
    else if (r_all_high && r_high_cnt != CNT_MAX) r_high_cnt <= r_high_cnt + 1'b1;
  end

  assign high_cnt = r_high_cnt;
`else
  logic w_unused_clr;

  assign w_unused_clr = cnt_clr;
  assign high_cnt     = '0;
`endif

endmodule

// File: tb/tb_better_and_gate.sv
// Directed bench for better_and_gate: WIDTH=1, WIDTH=8 and a CNT_W=4 instance.
`timescale 1ns/1ps
module tb_better_and_gate;

  logic       clk = 1'b0;
  logic       rst;
  logic       a1, b1, clr1;
  logic       a4, b4, clr4;
  logic [7:0] a8, b8;
  logic       clr8;

  logic        out1, out_q1, ah1, rise1, fall1;
  logic [15:0] cnt1;
  logic        out4, out_q4, ah4, rise4, fall4;
  logic [3:0]  cnt4;
  logic [7:0]  out8, out_q8;
  logic        ah8, rise8, fall8;
  logic [15:0] cnt8;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  better_and_gate #(.WIDTH(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cnt_clr(clr1),
    .out(out1), .out_q(out_q1), .all_high(ah1), .rise(rise1), .fall(fall1),
    .high_cnt(cnt1));

  better_and_gate #(.WIDTH(1), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cnt_clr(clr4),
    .out(out4), .out_q(out_q4), .all_high(ah4), .rise(rise4), .fall(fall4),
    .high_cnt(cnt4));

  better_and_gate #(.WIDTH(8), .CNT_W(16)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cnt_clr(clr8),
    .out(out8), .out_q(out_q8), .all_high(ah8), .rise(rise8), .fall(fall8),
    .high_cnt(cnt8));

  function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef BETTER_AND_GATE_STATS_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check1(input string tag, input logic q, input logic ah, input logic r,
                        input logic f, input logic [31:0] c);
    check({tag, ".out_q"},    {31'd0, out_q1}, {31'd0, q});
    check({tag, ".all_high"}, {31'd0, ah1},    {31'd0, ah});
    check({tag, ".rise"},     {31'd0, rise1},  {31'd0, r});
    check({tag, ".fall"},     {31'd0, fall1},  {31'd0, f});
    check({tag, ".high_cnt"}, {16'd0, cnt1},   exp_cnt(c));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] vec [8];
    logic       exp_out [8];
    vec     = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    exp_out = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    a1 = 0; b1 = 0; clr1 = 0;
    a4 = 0; b4 = 0; clr4 = 0;
    a8 = 8'h00; b8 = 8'h00; clr8 = 0;
    #2;
    check1("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Combinational path while held in reset
    for (int i = 0; i < 8; i++) begin
      a1 = vec[i][1];
      b1 = vec[i][0];
      #1;
      check($sformatf("comb_seq[%0d]", i), {31'd0, out1}, {31'd0, exp_out[i]});
      check($sformatf("comb_seq_q[%0d]", i), {31'd0, out_q1}, 32'd0);
      #9;
    end

    a8 = 8'hF0; b8 = 8'h3C;
    #1;
    check("w8_comb", {24'd0, out8}, 32'h30);

    // Release reset with a=b=1: rise must pulse at the first edge
    @(negedge clk);
    rst = 1'b0;
    a1 = 1; b1 = 1;
    tick(1);
    check1("first_edge", 1'b1, 1'b1, 1'b1, 1'b0, 0);
    check("w8_out_q", {24'd0, out_q8}, 32'h30);
    check("w8_all_high", {31'd0, ah8}, 32'd0);

    tick(1);
    check1("hold1", 1'b1, 1'b1, 1'b0, 1'b0, 1);

    // Glitch on b between edges must not reach registered outputs
    b1 = 0;
    #1;
    check("glitch_comb", {31'd0, out1}, 32'd0);
    b1 = 1;
    tick(1);
    check1("hold2", 1'b1, 1'b1, 1'b0, 1'b0, 2);

    b1 = 0;
    tick(1);
    check("drop_out", {31'd0, out1}, 32'd0);
    check1("fall_edge", 1'b0, 1'b0, 1'b0, 1'b1, 3);
    tick(1);
    check1("after_fall", 1'b0, 1'b0, 1'b0, 1'b0, 3);

    a8 = 8'hFF; b8 = 8'hFF;
    tick(1);
    check("w8_ff_all_high", {31'd0, ah8}, 32'd1);
    check("w8_ff_rise", {31'd0, rise8}, 32'd1);
    a8 = 8'hFF; b8 = 8'h7F;
    tick(1);
    check("w8_7f_out_q", {24'd0, out_q8}, 32'h7F);
    check("w8_7f_fall", {31'd0, fall8}, 32'd1);

    // Build count to 5, then assert reset between edges
    b1 = 1;
    tick(2);
    check1("recount", 1'b1, 1'b1, 1'b0, 1'b0, 4);
    tick(1);
    check("cnt5", {16'd0, cnt1}, exp_cnt(5));
    #2;
    rst = 1'b1;
    #1;
    check1("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("mid_reset_out", {31'd0, out1}, 32'd1);
    @(negedge clk);
    check1("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b0;
    tick(1);
    check1("rerise", 1'b1, 1'b1, 1'b1, 1'b0, 0);

    // Saturation on the 4-bit counter, then clear with a=b=1
    a4 = 1; b4 = 1;
    tick(20);
    check("sat_cnt", {28'd0, cnt4}, exp_cnt(15));
    check("sat_all_high", {31'd0, ah4}, 32'd1);
    tick(1);
    check("sat_hold", {28'd0, cnt4}, exp_cnt(15));
    clr4 = 1;
    tick(1);
    check("clr_cnt", {28'd0, cnt4}, exp_cnt(0));
    clr4 = 0;
    tick(1);
    check("clr_resume", {28'd0, cnt4}, exp_cnt(1));
    check("clr_no_edge", {30'd0, rise4, fall4}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
